// File: rtl/seg_mux_pkg.sv
// Shared types and constants for the two-digit seven-segment multiplexer.
// The state set depends on SEG_DEADTIME_EN (GAP states exist only when it is defined).
package seg_mux_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_DIG0   = 2'b10;
  localparam logic [1:0] AN_DIG1   = 2'b01;

`ifdef SEG_DEADTIME_EN
  typedef enum logic [1:0] {SHOW0, GAP0, SHOW1, GAP1} state_e;
`else
  typedef enum logic {SHOW0, SHOW1} state_e;
`endif

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex to seven-segment decoder, active-low, bit order {g,f,e,d,c,b,a}.
module seven_seg_decoder (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b1111111;
    unique case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/seg_mux_ctrl.sv
// Two-digit seven-segment multiplexer with registered seg/an and a registered s0+s1 sum.
// Define SEG_DEADTIME_EN to insert DEAD_CYCLES of blanking between digits.
module seg_mux_ctrl
  import seg_mux_pkg::*;
#(
  parameter int REFRESH_DIV = 24000,
  parameter int DEAD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [4:0] led
);

`ifdef SEG_DEADTIME_EN
  localparam int MAX_N = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
`else
  localparam int MAX_N = REFRESH_DIV;
`endif
  localparam int CNT_W = $clog2(MAX_N);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
`ifdef SEG_DEADTIME_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DEAD_CYCLES - 1);
`endif

  if (REFRESH_DIV < 2) begin : g_chk_refresh
    $error("seg_mux_ctrl: REFRESH_DIV must be at least 2");
  end
`ifdef SEG_DEADTIME_EN
  if (DEAD_CYCLES < 1) begin : g_chk_dead
    $error("seg_mux_ctrl: DEAD_CYCLES must be at least 1");
  end
`else
  // DEAD_CYCLES has no effect without blanking; referenced only to keep it declared.
  if (DEAD_CYCLES < 0) begin : g_dead_ignored
  end
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dig0_q, dig0_d, dig1_q, dig1_d;
  logic [3:0]       dec_in;
  logic [6:0]       dec_seg;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic [4:0]       led_q;

  always_comb begin
    state_d = state_q;
    dig0_d  = dig0_q;
    dig1_d  = dig1_q;
    unique case (state_q)
`ifdef SEG_DEADTIME_EN
      SHOW0: if (cnt_q == SHOW_LAST) state_d = GAP0;
      GAP0: if (cnt_q == GAP_LAST) begin
        state_d = SHOW1;
        dig1_d  = s1;
      end
      SHOW1: if (cnt_q == SHOW_LAST) state_d = GAP1;
      GAP1: if (cnt_q == GAP_LAST) begin
        state_d = SHOW0;
        dig0_d  = s0;
      end
`else
      SHOW0: if (cnt_q == SHOW_LAST) begin
        state_d = SHOW1;
        dig1_d  = s1;
      end
      SHOW1: if (cnt_q == SHOW_LAST) begin
        state_d = SHOW0;
        dig0_d  = s0;
      end
`endif
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  // Decoder sees the digit being latched this edge so seg updates with the state register.
  assign dec_in = (state_d == SHOW1) ? dig1_d : dig0_d;

  seven_seg_decoder u_dec (
    .hex_i (dec_in),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    unique case (state_d)
      SHOW0: begin
        seg_d = dec_seg;
        an_d  = AN_DIG0;
      end
      SHOW1: begin
        seg_d = dec_seg;
        an_d  = AN_DIG1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef SEG_DEADTIME_EN
      state_q <= GAP1;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
`else
      state_q <= SHOW0;
      seg_q   <= SEG_ZERO;
      an_q    <= AN_DIG0;
`endif
      cnt_q   <= '0;
      dig0_q  <= '0;
      dig1_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig0_q  <= dig0_d;
      dig1_q  <= dig1_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      led_q   <= {1'b0, s0} + {1'b0, s1};
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign led = led_q;

endmodule

// File: tb/tb_seg_mux_ctrl.sv
// Directed bench for seg_mux_ctrl with REFRESH_DIV=4, DEAD_CYCLES=2; follows SEG_DEADTIME_EN.
module tb_seg_mux_ctrl;

  localparam int R = 4;
`ifdef SEG_DEADTIME_EN
  localparam int D = 2;
  localparam logic [1:0] RST_AN  = 2'b11;
  localparam logic [6:0] RST_SEG = 7'h7F;
`else
  localparam int D = 0;
  localparam logic [1:0] RST_AN  = 2'b10;
  localparam logic [6:0] RST_SEG = 7'b1000000;
`endif
  localparam int P = 2 * R + 2 * D;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] s0 = 4'h0;
  logic [3:0] s1 = 4'h0;
  logic [6:0] seg;
  logic [1:0] an;
  logic [4:0] led;

  int vectors = 0;
  int miscompares = 0;

  int         idx = 0;
  logic [3:0] m_d0 = 4'h0;
  logic [3:0] m_d1 = 4'h0;
  logic [6:0] exp_seg;
  logic [1:0] exp_an;
  logic [4:0] exp_led;

  seg_mux_ctrl #(.REFRESH_DIV(R), .DEAD_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .s0    (s0),
    .s1    (s1),
    .seg   (seg),
    .an    (an),
    .led   (led)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] golden(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Advance one clock and update the reference schedule; idx 0 is the last reset edge.
  task automatic step();
    logic [3:0] a0, a1;
    logic       rst;
    int         p;
    a0 = s0;
    a1 = s1;
    rst = reset;
    @(posedge clk);
    #1;
    if (rst) begin
      idx = 0;
      m_d0 = 4'h0;
      m_d1 = 4'h0;
      exp_led = 5'd0;
    end else begin
      idx++;
      exp_led = {1'b0, a0} + {1'b0, a1};
      if (idx % P == D) m_d0 = a0;
      if (idx % P == 2 * D + R) m_d1 = a1;
    end
    p = idx % P;
    if (p < D || (p >= D + R && p < 2 * D + R)) begin
      exp_an = 2'b11;
      exp_seg = 7'h7F;
    end else if (p < D + R) begin
      exp_an = 2'b10;
      exp_seg = golden(m_d0);
    end else begin
      exp_an = 2'b01;
      exp_seg = golden(m_d1);
    end
  endtask

  task automatic advance_to(input int target);
    for (int k = 0; k < P && (idx % P) != target; k++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s0 = 4'h3;
    s1 = 4'h4;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (an !== RST_AN) begin
        miscompares++;
        $display("FAIL reset_an cycle %0d: got %b expected %b", i, an, RST_AN);
      end
      vectors++;
      if (seg !== RST_SEG) begin
        miscompares++;
        $display("FAIL reset_seg cycle %0d: got %b expected %b", i, seg, RST_SEG);
      end
      vectors++;
      if (led !== 5'd0) begin
        miscompares++;
        $display("FAIL reset_led cycle %0d: got %0d expected 0", i, led);
      end
    end
  endtask

  task automatic test_basic();
    reset = 1'b0;
    s0 = 4'h1;
    s1 = 4'h8;
    for (int i = 0; i < 2 * P; i++) begin
      step();
      vectors++;
      if (an !== exp_an || seg !== exp_seg || led !== exp_led || an === 2'b00) begin
        miscompares++;
        $display("FAIL basic idx %0d: got an=%b seg=%b led=%0d expected an=%b seg=%b led=%0d",
                 idx, an, seg, led, exp_an, exp_seg, exp_led);
      end
    end
  endtask

  task automatic test_latch();
    advance_to(D);
    step();
    s0 = 4'hA;
    for (int i = 0; i < R - 2; i++) begin
      step();
      vectors++;
      if (seg !== 7'b1111001 || an !== 2'b10) begin
        miscompares++;
        $display("FAIL latch_hold idx %0d: got an=%b seg=%b expected an=10 seg=1111001", idx, an, seg);
      end
    end
    for (int k = 0; k < P && (idx % P) != D; k++) begin
      step();
      vectors++;
      if (an !== exp_an || seg !== exp_seg) begin
        miscompares++;
        $display("FAIL latch_run idx %0d: got an=%b seg=%b expected an=%b seg=%b",
                 idx, an, seg, exp_an, exp_seg);
      end
    end
    vectors++;
    if (seg !== 7'b0001000 || an !== 2'b10) begin
      miscompares++;
      $display("FAIL latch_new idx %0d: got an=%b seg=%b expected an=10 seg=0001000", idx, an, seg);
    end
  endtask

  task automatic test_reset_mid();
    advance_to(2 * D + R + 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (an !== RST_AN || seg !== RST_SEG || led !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got an=%b seg=%b led=%0d expected an=%b seg=%b led=0",
               an, seg, led, RST_AN, RST_SEG);
    end
    for (int i = 0; i < P; i++) begin
      step();
      vectors++;
      if (an !== exp_an || seg !== exp_seg) begin
        miscompares++;
        $display("FAIL reset_mid_resume idx %0d: got an=%b seg=%b expected an=%b seg=%b",
                 idx, an, seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_led();
    s0 = 4'hF;
    s1 = 4'hF;
    step();
    vectors++;
    if (led !== 5'd30) begin
      miscompares++;
      $display("FAIL led_max: got %0d expected 30", led);
    end
    s0 = 4'h0;
    s1 = 4'h0;
    step();
    vectors++;
    if (led !== 5'd0) begin
      miscompares++;
      $display("FAIL led_zero: got %0d expected 0", led);
    end
    s0 = 4'h7;
    s1 = 4'h9;
    step();
    vectors++;
    if (led !== 5'd16) begin
      miscompares++;
      $display("FAIL led_carry: got %0d expected 16", led);
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      s0 = 4'(v);
      step();
      advance_to(D);
      vectors++;
      if (seg !== golden(4'(v)) || an !== 2'b10) begin
        miscompares++;
        $display("FAIL sweep digit %0h: got an=%b seg=%b expected an=10 seg=%b",
                 v, an, seg, golden(4'(v)));
      end
    end
  endtask

  task automatic test_no_deadtime();
    for (int i = 0; i < 4 * R; i++) begin
      step();
      vectors++;
      if (an === 2'b11 || an === 2'b00 || an !== exp_an) begin
        miscompares++;
        $display("FAIL alternate idx %0d: got an=%b expected %b", idx, an, exp_an);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latch();
    test_reset_mid();
    test_led();
    test_sweep();
`ifndef SEG_DEADTIME_EN
    test_no_deadtime();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
